// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared definitions for the data-memory arbiter: FSM state
//            encoding, requester port indices, default geometry and a small
//            port-to-one-hot helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  // Transaction sequencer states: grant in IDLE, strobe memory in ACCESS,
  // pulse the response in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester indices
  localparam logic PORT_PIPE = 1'b0;  // pipeline MEM stage
  localparam logic PORT_DBG  = 1'b1;  // debug / DMA loader

  // Default geometry of the shared data memory
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 32;

  // Convert a port index into its one-hot request/response lane.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundle of the two-port request/response handshake plus the
//            memory-side control bus of the data-memory arbiter.
// Ports    : req_valid/req_write/req_addr*/req_wdata* - requests (2 ports)
//            req_ready/resp_valid/resp_err/resp_rdata  - handshake/response
//            pipe_stall                                 - pipeline hold
//            mem_addr/mem_wdata/mem_write/mem_read      - to memory
//            mem_rdata                                  - from memory
// Modports : slave  - the arbiter
//            master - the environment (requesters plus the memory array)
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  // Request side, [0]=pipeline, [1]=debug
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;

  // Response side (read data lane is shared by both ports)
  logic [1:0]        resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              pipe_stall;

  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, pipe_stall,
    output mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, pipe_stall,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-requester round-robin arbiter. A lone requester always
//            wins; on a tie the port that did not win last time wins.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            req[1:0]   - request vector
//            advance    - current grant is being taken; remember the winner
//            grant[1:0] - one-hot grant (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = port_onehot(~r_last_grant);
      default: grant = 2'b00;
    endcase
  end

  // Reset to the debug port so the pipeline port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT_DBG;
    end else if (advance && (grant != 2'b00)) begin
      r_last_grant <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between the pipeline MEM stage
//            (port 0) and a debug/DMA loader (port 1). One transaction in
//            flight at a time: grant in IDLE, registered memory strobe in
//            ACCESS, one-cycle response pulse in RESP.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset, aborts any transaction
//            bus  - dmem_arbiter_if.slave (requests, responses, pipe_stall,
//                   memory control and returned read data)
// Params   : DATA_W - data width, ADDR_W - address width,
//            DEPTH  - memory words; addresses >= DEPTH are rejected
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_next_state;

  logic [1:0]        w_arb_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic [1:0]        w_req_ready;

  logic              w_sel_port;
  logic              w_sel_write;
  logic              w_sel_err;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Transaction latch
  logic              r_port;
  logic              r_err;

  // Registered outputs
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_write;
  logic              r_mem_read;
  logic [1:0]        r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  // --------------------------------------------------------------------------
  // Arbitration. Requests are only offered to the arbiter while idle and out
  // of reset, so a grant can only be produced in a cycle where it is taken.
  // --------------------------------------------------------------------------
  assign w_arb_req = bus.req_valid & {2{(r_state == IDLE) && !rst}};

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .rst     (rst),
    .req     (w_arb_req),
    .advance (w_accept),
    .grant   (w_grant)
  );

  // Payload of the winning port
  assign w_sel_port  = w_grant[1];
  assign w_sel_write = bus.req_write[w_sel_port];
  assign w_sel_addr  = w_sel_port ? bus.req_addr1  : bus.req_addr0;
  assign w_sel_wdata = w_sel_port ? bus.req_wdata1 : bus.req_wdata0;
  assign w_sel_err   = (w_sel_addr >= DEPTH_A);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_req_ready  = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_grant != 2'b00) begin
          w_accept     = 1'b1;
          w_req_ready  = w_grant;
          w_next_state = ACCESS;
        end
      end
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction latch, memory drive and response registers.
  // The latched address/data are the memory address/data outputs themselves,
  // so they naturally hold their last value outside ACCESS. The strobes are
  // loaded on the grant edge, which makes them high for exactly the ACCESS
  // cycle and glitch-free at the memory.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port       <= PORT_PIPE;
      r_err        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_resp_valid <= 2'b00;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_resp_valid <= 2'b00;
      r_resp_err   <= 1'b0;

      if (w_accept) begin
        r_port      <= w_sel_port;
        r_err       <= w_sel_err;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_write <=  w_sel_write && !w_sel_err;
        r_mem_read  <= !w_sel_write && !w_sel_err;
      end

      // End of ACCESS: capture the memory's combinational read data only for
      // a strobed read; writes and rejected addresses return zero.
      if (r_state == ACCESS) begin
        r_resp_rdata <= r_mem_read ? bus.mem_rdata : '0;
        r_resp_valid <= port_onehot(r_port);
        r_resp_err   <= r_err;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_read   = r_mem_read;

  // The pipeline must hold while its request waits for a grant or while its
  // own transaction is still being serviced.
  assign bus.pipe_stall = (bus.req_valid[0] && !w_req_ready[0]) ||
                          ((r_state != IDLE) && (r_port == PORT_PIPE));

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A behavioural model tracks
//            the busy window of the shared memory, the round-robin rule and
//            the memory contents; expected responses go into a scoreboard
//            queue that an independent monitor drains on every resp_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          NW   = 32;
  localparam logic [31:0] NW_A = 32'd32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit checking = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Physical memory behind the arbiter, preloaded with data[i] = i
  // --------------------------------------------------------------------------
  logic [31:0] phys [NW];
  initial begin
    for (int i = 0; i < NW; i++) phys[i] = 32'(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write === 1'b1 && bus.mem_addr < NW_A)
        phys[bus.mem_addr[4:0]] = bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = (bus.mem_addr < NW_A) ? phys[bus.mem_addr[4:0]] : 32'h0;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  onehot;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } resp_t;
  resp_t exp_q[$];

  // Monitor: runs on the falling edge, before the model updates the queue.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (checking) begin
        if (bus.resp_valid !== 2'b00) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL resp_unexpected: got resp_valid=%b expected none (cycle %0d)",
                     bus.resp_valid, cyc);
          end else begin
            r = exp_q.pop_front();
            chk("resp_port",  32'(bus.resp_valid), 32'(r.onehot));
            chk("resp_err",   32'(bus.resp_err),   32'(r.err));
            chk("resp_rdata", bus.resp_rdata,      r.rdata);
            chk("resp_cycle", 32'(cyc),            32'(r.due));
          end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          tests++;
          fails++;
          $display("FAIL resp_missing: got no resp_valid expected port %b at cycle %0d (now %0d)",
                   exp_q[0].onehot, exp_q[0].due, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: the memory is busy for the grant cycle plus two more;
  // a grant goes to the lone requester or, on a tie, away from the last one.
  // --------------------------------------------------------------------------
  logic [31:0] mdl_mem [NW];
  initial begin
    int          busy;
    logic        last, cur_port, win, w, err, inflight;
    logic        exp_mw, exp_mr, nmw, nmr;
    logic [31:0] exp_ma, exp_md, a, d, rd;
    logic [1:0]  eready;
    for (int i = 0; i < NW; i++) mdl_mem[i] = 32'(i);
    busy = 0; last = 1'b1; cur_port = 1'b0; win = 1'b0;
    exp_mw = 1'b0; exp_mr = 1'b0; exp_ma = '0; exp_md = '0;
    forever begin
      @(negedge clk);
      #1;
      if (checking) begin
        chk("mem_write", 32'(bus.mem_write), 32'(exp_mw));
        chk("mem_read",  32'(bus.mem_read),  32'(exp_mr));
        if (exp_mw || exp_mr) chk("mem_addr", bus.mem_addr, exp_ma);
        if (exp_mw)           chk("mem_wdata", bus.mem_wdata, exp_md);

        inflight = (busy != 0) && (cur_port == 1'b0);
        eready   = 2'b00;
        if (!rst && busy == 0 && bus.req_valid != 2'b00) begin
          win    = (bus.req_valid == 2'b11) ? ~last : bus.req_valid[1];
          eready = win ? 2'b10 : 2'b01;
        end
        chk("req_ready",  32'(bus.req_ready), 32'(eready));
        chk("pipe_stall", 32'(bus.pipe_stall),
            32'((bus.req_valid[0] && !eready[0]) || inflight));

        nmw = 1'b0;
        nmr = 1'b0;
        if (rst) begin
          busy = 0; last = 1'b1; cur_port = 1'b0;
          exp_q.delete();
        end else if (eready != 2'b00) begin
          a   = win ? bus.req_addr1  : bus.req_addr0;
          d   = win ? bus.req_wdata1 : bus.req_wdata0;
          w   = bus.req_write[win];
          err = (a >= NW_A);
          rd  = 32'h0;
          if (!err) begin
            if (w) mdl_mem[a[4:0]] = d;
            else   rd = mdl_mem[a[4:0]];
          end
          exp_q.push_back('{onehot: eready, err: err, rdata: rd, due: cyc + 2});
          nmw = w && !err;
          nmr = !w && !err;
          exp_ma = a;
          exp_md = d;
          last = win; cur_port = win; busy = 2;
        end else if (busy != 0) begin
          busy--;
        end
        exp_mw = nmw;
        exp_mr = nmr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_write[p] = w;
    if (p == 0) begin bus.req_addr0 = a; bus.req_wdata0 = d; end
    else        begin bus.req_addr1 = a; bus.req_wdata1 = d; end
    bus.req_valid[p] = 1'b1;
  endtask

  // Hold the request until ready is seen at a falling edge (bounded).
  task automatic wait_ready(input int p, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready[p] === 1'b1) ok = 1'b1;
      else step();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: got no req_ready[%0d] expected it within 12 cycles", name, p);
    end
  endtask

  task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input string name);
    set_req(p, w, a, d);
    wait_ready(p, name);
    step();
    bus.req_valid[p] = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [1:0]  grants[$];
    logic [1:0]  got;
    logic [31:0] ra;
    bus.req_valid = 2'b00; bus.req_write = 2'b00;
    bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    rst = 1'b1;

    step();
    checking = 1'b1;
    @(negedge clk);
    chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
    chk("rst_mem_addr",   bus.mem_addr,        32'h0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'h0);
    chk("rst_mem_strobe", 32'({bus.mem_write, bus.mem_read}), 32'h0);
    chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'h0);
    step();
    rst = 1'b0;

    // Single read, write-then-read across ports, out-of-range access
    do_req(0, 1'b0, 32'd5, 32'h0, "read5");
    idle(4);
    do_req(1, 1'b1, 32'd7, 32'hDEADBEEF, "wr7");
    do_req(0, 1'b0, 32'd7, 32'h0, "rd7");
    idle(4);
    do_req(1, 1'b0, 32'd32, 32'h0, "oor");
    idle(4);

    // Contention straight out of reset: grants must alternate 0,1,0,1
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1'b0, 32'd10, 32'h0);
    set_req(1, 1'b0, 32'd11, 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) grants.push_back(bus.req_ready);
      step();
    end
    bus.req_valid = 2'b00;
    chk("contention_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++)
      chk("contention_order", 32'(grants[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    idle(4);

    // Reset during ACCESS of a port 0 write aborts the response
    set_req(0, 1'b1, 32'd3, 32'h0BAD_F00D);
    wait_ready(0, "abort_wr");
    step();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b0, 32'd3, 32'h0);
    set_req(1, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    chk("abort_quiet", 32'({bus.resp_valid, bus.mem_write, bus.mem_read}), 32'h0);
    chk("abort_prio",  32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 2'b00;
    idle(4);

    // Port 1 withdraws a one-cycle request while port 0 is in flight
    set_req(0, 1'b0, 32'd2, 32'h0);
    wait_ready(0, "wd_rd");
    step();
    bus.req_valid[0] = 1'b0;
    set_req(1, 1'b1, 32'd9, 32'h1234_5678);
    step();
    bus.req_valid[1] = 1'b0;
    idle(5);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      got = bus.req_ready;
      step();
      rst = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && !got[p] && $urandom_range(0, 7) != 0) continue;
        if ($urandom_range(0, 2) == 0) begin
          ra = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 35));
          set_req(p, 1'($urandom_range(0, 1)), ra, 32'($urandom));
        end else begin
          bus.req_valid[p] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    bus.req_valid = 2'b00;
    idle(6);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
